// File: rtl/nco_pkg.sv
// Shared types and helpers for the polyphonic NCO bank.
package nco_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } nco_state_e;

  localparam logic [1:0] CFG_INC    = 2'd0;
  localparam logic [1:0] CFG_OFF    = 2'd1;
  localparam logic [1:0] CFG_PRESET = 2'd2;
  localparam logic [1:0] CFG_CTRL   = 2'd3;

  function automatic int voice_idx_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nco_voice_regs.sv
// Per-voice increment/offset/enable/accumulator storage: one read port, one
// accumulator write-back port, one config port. Sync bits exist only with NCO_HARD_SYNC_EN.
module nco_voice_regs
  import nco_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int ADDR_BITS  = 8,
  parameter int ACC_BITS   = 24,
  parameter int INC_BITS   = 16,
  localparam int VW        = voice_idx_bits(NUM_VOICES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [VW-1:0]        rd_idx_i,
  output logic [INC_BITS-1:0]  rd_inc_o,
  output logic [ADDR_BITS-1:0] rd_off_o,
  output logic                 rd_en_o,
  output logic [ACC_BITS-1:0]  rd_acc_o,
`ifdef NCO_HARD_SYNC_EN
  output logic                 rd_sync_o,
`endif
  input  logic                 acc_we_i,
  input  logic [VW-1:0]        acc_idx_i,
  input  logic [ACC_BITS-1:0]  acc_wdata_i,
  input  logic                 cfg_we_i,
  input  logic [VW-1:0]        cfg_voice_i,
  input  logic [1:0]           cfg_sel_i,
  input  logic [INC_BITS-1:0]  cfg_data_i
);

  logic [INC_BITS-1:0]  inc_q [NUM_VOICES];
  logic [ADDR_BITS-1:0] off_q [NUM_VOICES];
  logic                 en_q  [NUM_VOICES];
  logic [ACC_BITS-1:0]  acc_q [NUM_VOICES];
`ifdef NCO_HARD_SYNC_EN
  logic                 sync_q [NUM_VOICES];
  assign rd_sync_o = sync_q[rd_idx_i];
`endif

  assign rd_inc_o = inc_q[rd_idx_i];
  assign rd_off_o = off_q[rd_idx_i];
  assign rd_en_o  = en_q[rd_idx_i];
  assign rd_acc_o = acc_q[rd_idx_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        inc_q[i] <= '0;
        off_q[i] <= '0;
        en_q[i]  <= 1'b0;
        acc_q[i] <= '0;
`ifdef NCO_HARD_SYNC_EN
        sync_q[i] <= 1'b0;
`endif
      end
    end else begin
      if (acc_we_i)
        acc_q[acc_idx_i] <= acc_wdata_i;
      // Config comes second so a preset overrides a same-cycle write-back.
      if (cfg_we_i) begin
        case (cfg_sel_i)
          CFG_INC:    inc_q[cfg_voice_i] <= cfg_data_i;
          CFG_OFF:    off_q[cfg_voice_i] <= cfg_data_i[ADDR_BITS-1:0];
          CFG_PRESET: acc_q[cfg_voice_i] <= {cfg_data_i[ADDR_BITS-1:0], {(ACC_BITS-ADDR_BITS){1'b0}}};
          default: begin
            en_q[cfg_voice_i] <= cfg_data_i[0];
`ifdef NCO_HARD_SYNC_EN
            sync_q[cfg_voice_i] <= cfg_data_i[1];
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/poly_nco_bank.sv
// Time-multiplexed bank of fractional phase-accumulator NCOs, one voice per cycle per sweep.
// Optional hard sync between adjacent voices is built with NCO_HARD_SYNC_EN.
module poly_nco_bank
  import nco_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int ADDR_BITS  = 8,
  parameter int ACC_BITS   = 24,
  parameter int INC_BITS   = 16,
  localparam int VW        = voice_idx_bits(NUM_VOICES)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 sample_tick,
  input  logic                 cfg_we,
  input  logic [VW-1:0]        cfg_voice,
  input  logic [1:0]           cfg_sel,
  input  logic [INC_BITS-1:0]  cfg_data,
  output logic                 out_valid,
  output logic [VW-1:0]        out_voice,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic                 out_wrap,
  output logic                 sweep_busy,
  output logic                 tick_overrun,
  input  logic                 overrun_clr
);

  nco_state_e           state_q, state_d;
  logic [VW-1:0]        vcnt_q, vcnt_d;
  logic                 valid_q, wrap_q, ovr_q, ovr_d;
  logic [VW-1:0]        voice_q;
  logic [ADDR_BITS-1:0] addr_q;

  logic [INC_BITS-1:0]  rd_inc;
  logic [ADDR_BITS-1:0] rd_off;
  logic                 rd_en;
  logic [ACC_BITS-1:0]  rd_acc;
  logic [ACC_BITS:0]    sum;
  logic [ACC_BITS-1:0]  acc_n;
  logic                 wrap_n, busy, last;
  logic [ADDR_BITS-1:0] addr_n;
`ifdef NCO_HARD_SYNC_EN
  logic                 rd_sync;
  logic                 chain_q;
`endif

  nco_voice_regs #(
    .NUM_VOICES(NUM_VOICES), .ADDR_BITS(ADDR_BITS),
    .ACC_BITS(ACC_BITS), .INC_BITS(INC_BITS)
  ) u_regs (
    .clk_i(sys_clk), .rst_i(sys_rst),
    .rd_idx_i(vcnt_q), .rd_inc_o(rd_inc), .rd_off_o(rd_off),
    .rd_en_o(rd_en), .rd_acc_o(rd_acc),
`ifdef NCO_HARD_SYNC_EN
    .rd_sync_o(rd_sync),
`endif
    .acc_we_i(busy), .acc_idx_i(vcnt_q), .acc_wdata_i(acc_n),
    .cfg_we_i(cfg_we), .cfg_voice_i(cfg_voice), .cfg_sel_i(cfg_sel), .cfg_data_i(cfg_data)
  );

  assign busy = (state_q == ST_SWEEP);
  assign last = (vcnt_q == VW'(NUM_VOICES - 1));

  always_comb begin
    sum    = {1'b0, rd_acc} + (ACC_BITS + 1)'(rd_inc);
    acc_n  = rd_en ? sum[ACC_BITS-1:0] : rd_acc;
    wrap_n = rd_en & sum[ACC_BITS];
`ifdef NCO_HARD_SYNC_EN
    // chain_q holds the previous voice's wrap, carried across sweeps for voice 0.
    if (rd_sync && chain_q) begin
      acc_n  = '0;
      wrap_n = 1'b1;
    end
`endif
    addr_n = acc_n[ACC_BITS-1 -: ADDR_BITS] + rd_off;
  end

  always_comb begin
    state_d = state_q;
    vcnt_d  = vcnt_q;
    ovr_d   = ovr_q;
    if (busy) begin
      vcnt_d = vcnt_q + 1'b1;
      if (last) begin
        state_d = ST_IDLE;
        vcnt_d  = '0;
      end
    end else if (sample_tick) begin
      state_d = ST_SWEEP;
      vcnt_d  = '0;
    end
    if (overrun_clr)
      ovr_d = 1'b0;
    if (sample_tick && busy)
      ovr_d = 1'b1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      vcnt_q  <= '0;
      ovr_q   <= 1'b0;
      valid_q <= 1'b0;
      voice_q <= '0;
      addr_q  <= '0;
      wrap_q  <= 1'b0;
`ifdef NCO_HARD_SYNC_EN
      chain_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      vcnt_q  <= vcnt_d;
      ovr_q   <= ovr_d;
      valid_q <= busy;
      voice_q <= busy ? vcnt_q : '0;
      addr_q  <= busy ? addr_n : '0;
      wrap_q  <= busy & wrap_n;
`ifdef NCO_HARD_SYNC_EN
      if (busy)
        chain_q <= wrap_n;
`endif
    end
  end

  assign out_valid    = valid_q;
  assign out_voice    = voice_q;
  assign out_addr     = addr_q;
  assign out_wrap     = wrap_q;
  assign sweep_busy   = busy;
  assign tick_overrun = ovr_q;

endmodule

// File: tb/tb_poly_nco_bank.sv
// Directed bench for poly_nco_bank: vector table of config writes and sweeps,
// plus hand sequences for overrun, mid-sweep reset, write collisions and hard sync.
module tb_poly_nco_bank;

  localparam int NV   = 4;
  localparam int AB   = 8;
  localparam int ACCB = 16;
  localparam int IB   = 16;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          sample_tick = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_voice = '0;
  logic [1:0]    cfg_sel = '0;
  logic [IB-1:0] cfg_data = '0;
  logic          overrun_clr = 1'b0;
  logic          out_valid, out_wrap, sweep_busy, tick_overrun;
  logic [1:0]    out_voice;
  logic [AB-1:0] out_addr;

  poly_nco_bank #(.NUM_VOICES(NV), .ADDR_BITS(AB), .ACC_BITS(ACCB), .INC_BITS(IB)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sample_tick(sample_tick),
    .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_voice(out_voice), .out_addr(out_addr), .out_wrap(out_wrap),
    .sweep_busy(sweep_busy), .tick_overrun(tick_overrun), .overrun_clr(overrun_clr)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic            we;
    logic [1:0]      voice;
    logic [1:0]      sel;
    logic [15:0]     data;
    logic            tick;
    logic [3:0][7:0] ea;
    logic [3:0]      ew;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cfg_wr(input logic [1:0] v, input logic [1:0] s, input logic [15:0] d);
    @(negedge sys_clk);
    cfg_we = 1'b1; cfg_voice = v; cfg_sel = s; cfg_data = d;
    @(negedge sys_clk);
    cfg_we = 1'b0;
  endtask

  task automatic sweep(input string nm, input logic [3:0][7:0] ea, input logic [3:0] ew);
    @(negedge sys_clk);
    sample_tick = 1'b1;
    @(negedge sys_clk);
    sample_tick = 1'b0;
    chk({nm, " busy"}, 32'(sweep_busy), 32'd1);
    chk({nm, " early_valid"}, 32'(out_valid), 32'd0);
    for (int v = 0; v < NV; v++) begin
      @(negedge sys_clk);
      chk($sformatf("%s v%0d valid", nm, v), 32'(out_valid), 32'd1);
      chk($sformatf("%s v%0d voice", nm, v), 32'(out_voice), 32'(v));
      chk($sformatf("%s v%0d addr", nm, v), 32'(out_addr), 32'(ea[v]));
      chk($sformatf("%s v%0d wrap", nm, v), 32'(out_wrap), 32'(ew[v]));
    end
    @(negedge sys_clk);
    chk({nm, " late_valid"}, 32'(out_valid), 32'd0);
    chk({nm, " idle"}, 32'(sweep_busy), 32'd0);
  endtask

  // Config write aimed at voice 2 in the very cycle it is being processed.
  task automatic collide(input string nm, input logic [1:0] s, input logic [15:0] d, input logic [7:0] ea);
    @(negedge sys_clk); sample_tick = 1'b1;
    @(negedge sys_clk); sample_tick = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    cfg_we = 1'b1; cfg_voice = 2'd2; cfg_sel = s; cfg_data = d;
    @(negedge sys_clk);
    cfg_we = 1'b0;
    chk({nm, " voice"}, 32'(out_voice), 32'd2);
    chk({nm, " addr"}, 32'(out_addr), 32'(ea));
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] v, input logic [1:0] s,
                              input logic [15:0] d, input logic tk,
                              input logic [3:0][7:0] ea, input logic [3:0] ew);
    vec_t r;
    r.we = we; r.voice = v; r.sel = s; r.data = d; r.tick = tk; r.ea = ea; r.ew = ew;
    return r;
  endfunction

  initial begin
    int nv;

    // ea packed as {v3, v2, v1, v0}
    tbl[0]  = mk(1, 0, 0, 16'h0100, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000);
    tbl[1]  = mk(1, 0, 3, 16'h0001, 1, {8'h00, 8'h00, 8'h00, 8'h01}, 4'b0000);
    tbl[2]  = mk(0, 0, 0, 16'h0000, 1, {8'h00, 8'h00, 8'h00, 8'h02}, 4'b0000);
    tbl[3]  = mk(0, 0, 0, 16'h0000, 1, {8'h00, 8'h00, 8'h00, 8'h03}, 4'b0000);
    tbl[4]  = mk(1, 1, 0, 16'h0080, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000);
    tbl[5]  = mk(1, 1, 1, 16'h0040, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000);
    tbl[6]  = mk(1, 1, 3, 16'h0001, 1, {8'h00, 8'h00, 8'h40, 8'h04}, 4'b0000);
    tbl[7]  = mk(0, 0, 0, 16'h0000, 1, {8'h00, 8'h00, 8'h41, 8'h05}, 4'b0000);
    tbl[8]  = mk(1, 2, 2, 16'h00FF, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000);
    tbl[9]  = mk(1, 2, 0, 16'h0100, 0, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000);
    tbl[10] = mk(1, 2, 3, 16'h0001, 1, {8'h00, 8'h00, 8'h41, 8'h06}, 4'b0100);
    tbl[11] = mk(1, 0, 3, 16'h0000, 1, {8'h00, 8'h01, 8'h42, 8'h06}, 4'b0000);
    tbl[12] = mk(1, 1, 1, 16'h00FF, 1, {8'h00, 8'h02, 8'h01, 8'h06}, 4'b0000);
    tbl[13] = mk(1, 3, 1, 16'h00C5, 1, {8'hC5, 8'h03, 8'h02, 8'h06}, 4'b0000);

    repeat (2) @(negedge sys_clk);
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst addr", 32'(out_addr), 32'd0);
    chk("rst busy", 32'(sweep_busy), 32'd0);
    chk("rst overrun", 32'(tick_overrun), 32'd0);
    sys_rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].we) cfg_wr(tbl[i].voice, tbl[i].sel, tbl[i].data);
      if (tbl[i].tick) sweep($sformatf("vec%0d", i), tbl[i].ea, tbl[i].ew);
    end

    // Back-to-back ticks: second one ignored, exactly four valid outputs.
    nv = 0;
    @(negedge sys_clk);
    sample_tick = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge sys_clk);
      nv += int'(out_valid);
      sample_tick = (i == 1);
    end
    chk("overrun set", 32'(tick_overrun), 32'd1);
    chk("overrun valid_count", 32'(nv), 32'd4);
    @(negedge sys_clk); overrun_clr = 1'b1;
    @(negedge sys_clk); overrun_clr = 1'b0;
    chk("overrun clr", 32'(tick_overrun), 32'd0);

    // Set and clear in the same cycle: set wins.
    @(negedge sys_clk); sample_tick = 1'b1;
    @(negedge sys_clk); overrun_clr = 1'b1;
    @(negedge sys_clk); sample_tick = 1'b0; overrun_clr = 1'b0;
    chk("overrun set_wins", 32'(tick_overrun), 32'd1);
    repeat (6) @(negedge sys_clk);
    @(negedge sys_clk); overrun_clr = 1'b1;
    @(negedge sys_clk); overrun_clr = 1'b0;
    chk("overrun clr2", 32'(tick_overrun), 32'd0);

    // Reset while voice 2 is being processed.
    @(negedge sys_clk); sample_tick = 1'b1;
    @(negedge sys_clk); sample_tick = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    chk("midrst valid", 32'(out_valid), 32'd0);
    chk("midrst busy", 32'(sweep_busy), 32'd0);
    chk("midrst addr", 32'(out_addr), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    nv = 0;
    repeat (5) begin
      @(negedge sys_clk);
      nv += int'(out_valid);
    end
    chk("midrst no_partial", 32'(nv), 32'd0);
    sweep("postrst", {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000);

    // Same-cycle collisions on voice 2.
    cfg_wr(2'd2, 2'd0, 16'h0100);
    cfg_wr(2'd2, 2'd3, 16'h0001);
    collide("coll_preset", 2'd2, 16'h0080, 8'h01);
    collide("coll_inc", 2'd0, 16'h0200, 8'h81);
    sweep("after_coll", {8'h00, 8'h83, 8'h00, 8'h00}, 4'b0000);

`ifdef NCO_HARD_SYNC_EN
    do_reset();
    cfg_wr(2'd0, 2'd0, 16'h8000);
    cfg_wr(2'd0, 2'd3, 16'h0001);
    cfg_wr(2'd1, 2'd0, 16'h0100);
    cfg_wr(2'd1, 2'd3, 16'h0003);
    sweep("sync1", {8'h00, 8'h00, 8'h01, 8'h80}, 4'b0000);
    sweep("sync2", {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0011);
`else
    do_reset();
    cfg_wr(2'd0, 2'd0, 16'h8000);
    cfg_wr(2'd0, 2'd3, 16'h0001);
    cfg_wr(2'd1, 2'd0, 16'h0100);
    cfg_wr(2'd1, 2'd3, 16'h0003);
    sweep("nosync1", {8'h00, 8'h00, 8'h01, 8'h80}, 4'b0000);
    sweep("nosync2", {8'h00, 8'h00, 8'h02, 8'h00}, 4'b0001);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poly_nco_bank.md
Name: poly_nco_bank

Overview:
- Time-multiplexed bank of NUM_VOICES phase-accumulator NCOs feeding wavetable address generation for the polyphonic synth voices.
- Each voice has a fractional phase increment, a phase offset, a phase preset and an enable, all loaded through a config write port from the SPI control path.
- On each sample_tick the bank sweeps all voices, one per cycle, and emits one wavetable address per voice with a voice tag.
- This block replaces single-voice counter/divider NCOs with a true fractional accumulator.

Parameters:
- NUM_VOICES, 8: voice count. Power of two, 2..32.
- ADDR_BITS, 8: wavetable address width, taken from the accumulator MSBs.
- ACC_BITS, 24: phase accumulator width. Must be greater than ADDR_BITS.
- INC_BITS, 16: increment and cfg_data width. Must satisfy ADDR_BITS <= INC_BITS <= ACC_BITS.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous reset, active-high.
- sample_tick  in  1  single-cycle strobe that starts a sweep.
- cfg_we  in  1  config write strobe.
- cfg_voice  in  log2(NUM_VOICES)  target voice.
- cfg_sel  in  2  field select: 0 = increment, 1 = offset, 2 = phase preset, 3 = control bits.
- cfg_data  in  INC_BITS  write data.
- out_valid  out  1  out_addr, out_voice and out_wrap are valid this cycle.
- out_voice  out  log2(NUM_VOICES)  voice index of the current output.
- out_addr  out  ADDR_BITS  wavetable address.
- out_wrap  out  1  the accumulator overflowed during this update.
- sweep_busy  out  1  sweep in progress.
- tick_overrun  out  1  sticky flag: a tick arrived while busy.
- overrun_clr  in  1  clears tick_overrun.

Behaviour:
- Reset (async assert, sync release): all accumulators, increments, offsets and enables = 0. All outputs = 0. FSM = IDLE.
- FSM states: IDLE and SWEEP.
  - IDLE -> SWEEP on sample_tick; voice counter v = 0.
  - In SWEEP, one voice is processed per cycle. SWEEP -> IDLE after voice NUM_VOICES-1 is processed.
  - sweep_busy = 1 while in SWEEP.
- Processing voice v:
  - acc_n = acc[v] + zero_ext(inc[v]), modulo 2^ACC_BITS, if en[v]; otherwise acc_n = acc[v].
  - out_wrap = carry out of that addition (0 when the voice is disabled).
  - out_addr = (acc_n[ACC_BITS-1 -: ADDR_BITS] + off[v]) mod 2^ADDR_BITS.
  - The offset never modifies the accumulator.
- Latency: tick sampled at edge T; voice v outputs are registered at edge T+1+v. out_valid is high for exactly NUM_VOICES consecutive cycles and is otherwise 0.
- Disabled voices still emit an output (held address, wrap = 0).
- A sample_tick while in SWEEP is ignored and sets tick_overrun. overrun_clr clears it. If both occur in the same cycle, the set wins.
- Config writes are accepted in any state, one per cycle.
  - sel 0: inc = cfg_data.
  - sel 1: off = cfg_data[ADDR_BITS-1:0].
  - sel 3: en = cfg_data[0].
  - sel 2 (preset): acc = {cfg_data[ADDR_BITS-1:0], zeros}.
- Collision with the voice being processed in the same cycle:
  - inc, off and en writes take effect from the next sweep; the current update uses the old values.
  - A preset write wins over the accumulator update. The output in that cycle still reflects the old-value computation.
- sys_rst asserted mid-sweep: immediate return to IDLE, all state cleared. No partial outputs after release.

Optional Feature:
- Macro: NCO_HARD_SYNC_EN.
- With it defined:
  - cfg_sel 3, cfg_data[1] = sync[v].
  - A voice with sync[v] = 1 has acc_n forced to 0 (out_wrap = 1) when voice v-1 wrapped in the same sweep.
  - Voice 0 syncs to voice NUM_VOICES-1's wrap from the previous sweep, held in a 1-bit register that is 0 after reset.
- Without it: cfg_data[1] is ignored, no sync storage is built, and behaviour is exactly as above.

Decomposition:
- Shared package nco_pkg holds:
  - FSM state enum (ST_IDLE, ST_SWEEP).
  - cfg_sel constants (CFG_INC, CFG_OFF, CFG_PRESET, CFG_CTRL).
  - voice-index width function.
- One natural sub-module: nco_voice_regs, the per-voice inc/off/en/acc storage with one read port and a write port for the accumulator plus one for config. It maps to LUT/EBR RAM.

Test Plan (NUM_VOICES=4, ACC_BITS=16, ADDR_BITS=8, INC_BITS=16):
- Voice 0: inc = 0x0100, en = 1. Three ticks -> voice-0 out_addr = 0x01, 0x02, 0x03; voices 1-3 read 0x00; out_valid high for 4 cycles per tick, starting 1 cycle after the tick.
- Voice 1: inc = 0x0080, off = 0x40, en = 1. Two ticks -> out_addr = 0x40, then 0x41.
- Voice 2: preset 0xFF, inc = 0x0100, en = 1. One tick -> out_addr = 0x00, out_wrap = 1.
- Ticks on back-to-back cycles -> second tick ignored and tick_overrun = 1. Assert overrun_clr -> tick_overrun = 0.
- Assert sys_rst during voice-2 processing -> out_valid = 0 and sweep_busy = 0 immediately. The next tick yields out_addr = 0x00 for all voices.
- (NCO_HARD_SYNC_EN) Voice 0 inc = 0x8000; voice 1 inc = 0x0100 with sync = 1. Tick 2 -> voice 0 wraps, voice 1 out_addr = 0x00 with out_wrap = 1.
